// File: rtl/adc_capture_16ch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : adc_capture_16ch
// Description : Capture front end for 16 serial ADCs (U10..U25) sharing
//               CONVST, CS_n and SCLK. Each frame issues a conversion pulse,
//               waits for conversion, then clocks 16 bits MSB-first from every
//               SDO line in parallel and presents all 16 words at once.
// Ports       : CLK_50M    - system clock (sole clock)
//               RESET_n    - synchronous, active-low reset
//               ENABLE     - 1 = periodic sampling runs
//               SDO[15:0]  - serial data, bit i from chip U(10+i)
//               CONVST     - conversion start, active high
//               CS_n       - ADC chip select, active low
//               SCLK       - serial clock, idles low
//               DATA_OUT   - channel i word at [16*i+15:16*i]
//               DATA_VALID - one-cycle pulse when DATA_OUT updates
//               BUSY       - frame in progress
//               OVERRUN    - one-cycle pulse when a trigger is dropped
//               SAMPLE_CNT - completed frame count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_16ch #(
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 100,
    parameter int SAMPLE_PERIOD = 5000
) (
    input  logic         CLK_50M,
    input  logic         RESET_n,
    input  logic         ENABLE,
    input  logic [15:0]  SDO,
    output logic         CONVST,
    output logic         CS_n,
    output logic         SCLK,
    output logic [255:0] DATA_OUT,
    output logic         DATA_VALID,
    output logic         BUSY,
    output logic         OVERRUN,
    output logic [15:0]  SAMPLE_CNT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV  = 3'd1,
        S_WAIT  = 3'd2,
        S_SETUP = 3'd3,
        S_SHIFT = 3'd4,
        S_LATCH = 3'd5
    } state_t;

    localparam logic [15:0] c_conv_last   = 16'd3;
    localparam logic [15:0] c_wait_last   = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] c_div_last    = 16'(CLK_DIV - 1);
    localparam logic [23:0] c_period_last = 24'(SAMPLE_PERIOD - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_cnt;
    logic [15:0]       w_cnt_nxt;
    logic [3:0]        r_bit;
    logic [3:0]        w_bit_nxt;
    logic              r_phase;      // 0 = SCLK high half, 1 = low half
    logic              w_phase_nxt;
    logic [23:0]       r_period;
    logic [15:0][15:0] r_shift;
    logic              w_trigger;
    logic              w_sclk_nxt;
    logic              w_cs_n_nxt;
    logic              w_sample;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_phase_nxt = r_phase;
        w_trigger   = ENABLE && (r_period == '0);
        OVERRUN     = w_trigger && BUSY;

        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = S_CONV;
                    w_cnt_nxt   = '0;
                end
            end
            S_CONV: begin
                if (r_cnt == c_conv_last) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_WAIT: begin
                if (r_cnt == c_wait_last) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_SETUP: begin
                if (r_cnt == c_div_last) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_phase_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_div_last) begin
                    w_cnt_nxt = '0;
                    if (!r_phase) begin
                        // The 16th high half ends the frame directly; there is
                        // no trailing low half inside SHIFT.
                        if (r_bit == 4'd15) begin
                            w_state_nxt = S_LATCH;
                        end else begin
                            w_phase_nxt = 1'b1;
                        end
                    end else begin
                        w_phase_nxt = 1'b0;
                        w_bit_nxt   = r_bit + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            S_LATCH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_sclk_nxt = (w_state_nxt == S_SHIFT) && !w_phase_nxt;
        w_cs_n_nxt = !((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT));
        // Sample on the edge where the registered SCLK goes 0->1.
        w_sample   = w_sclk_nxt && !SCLK;
    end

    always_ff @(posedge CLK_50M) begin
        if (!RESET_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_phase    <= 1'b0;
            r_period   <= '0;
            r_shift    <= '0;
            CONVST     <= 1'b0;
            CS_n       <= 1'b1;
            SCLK       <= 1'b0;
            BUSY       <= 1'b0;
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            SAMPLE_CNT <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_phase <= w_phase_nxt;

            if (!ENABLE || (r_period == c_period_last)) begin
                r_period <= '0;
            end else begin
                r_period <= r_period + 24'd1;
            end

            CONVST <= (w_state_nxt == S_CONV);
            CS_n   <= w_cs_n_nxt;
            SCLK   <= w_sclk_nxt;
            BUSY   <= (w_state_nxt != S_IDLE);

            if (w_sample) begin
                for (int i = 0; i < 16; i++) begin
                    r_shift[i] <= {r_shift[i][14:0], SDO[i]};
                end
            end

            DATA_VALID <= (r_state == S_LATCH);
            if (r_state == S_LATCH) begin
                DATA_OUT   <= r_shift;
                SAMPLE_CNT <= SAMPLE_CNT + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_16ch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_adc_capture_16ch
// Description : Self-checking bench for adc_capture_16ch. Instance A runs a
//               400-cycle sample period with behavioural ADC models; instance
//               B runs a 100-cycle period with constant SDO to force overruns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_capture_16ch;

    localparam int L_CC = 100;
    localparam int L_CD = 2;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         RESET_n, ENABLE;
    logic [15:0]  SDO = '0;
    logic         CONVST, CS_n, SCLK, DATA_VALID, BUSY, OVERRUN;
    logic [255:0] DATA_OUT;
    logic [15:0]  SAMPLE_CNT;

    logic         RESET_n_b, ENABLE_b;
    logic [15:0]  SDO_b;
    logic         CONVST_b, CS_n_b, SCLK_b, DATA_VALID_b, BUSY_b, OVERRUN_b;
    logic [255:0] DATA_OUT_b;
    logic [15:0]  SAMPLE_CNT_b;

    adc_capture_16ch #(.CLK_DIV(L_CD), .CONV_CYCLES(L_CC), .SAMPLE_PERIOD(400)) u_dut_a (
        .CLK_50M(clk), .RESET_n(RESET_n), .ENABLE(ENABLE), .SDO(SDO),
        .CONVST(CONVST), .CS_n(CS_n), .SCLK(SCLK), .DATA_OUT(DATA_OUT),
        .DATA_VALID(DATA_VALID), .BUSY(BUSY), .OVERRUN(OVERRUN), .SAMPLE_CNT(SAMPLE_CNT)
    );

    adc_capture_16ch #(.CLK_DIV(L_CD), .CONV_CYCLES(L_CC), .SAMPLE_PERIOD(100)) u_dut_b (
        .CLK_50M(clk), .RESET_n(RESET_n_b), .ENABLE(ENABLE_b), .SDO(SDO_b),
        .CONVST(CONVST_b), .CS_n(CS_n_b), .SCLK(SCLK_b), .DATA_OUT(DATA_OUT_b),
        .DATA_VALID(DATA_VALID_b), .BUSY(BUSY_b), .OVERRUN(OVERRUN_b), .SAMPLE_CNT(SAMPLE_CNT_b)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [255:0] data;
        logic [15:0]  cnt;
        int           off;
    } exp_t;
    exp_t         sb[$];
    logic [255:0] last_exp = '0;

    function automatic logic [15:0] adc_word(input int f, input int ch);
        return 16'hA500 + 16'(ch) + 16'(f * 16);
    endfunction

    // ADC model: MSB appears when CS_n falls, next bit after each SCLK rise.
    int         m_frame = 0;
    int         m_idx   = 15;
    logic       m_prev_cs = 1'b1;
    logic       m_prev_sclk = 1'b0;
    logic [15:0] m_w;
    always @(negedge clk) begin
        if (CS_n !== 1'b0) begin
            if (m_prev_cs === 1'b0) m_frame++;
            m_idx = 15;
        end else if (SCLK === 1'b1 && m_prev_sclk === 1'b0) begin
            m_idx--;
        end
        m_prev_cs   = CS_n;
        m_prev_sclk = SCLK;
        for (int ch = 0; ch < 16; ch++) begin
            m_w     = adc_word(m_frame, ch);
            SDO[ch] = (m_idx >= 0) ? m_w[m_idx] : 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int f, input int off, input int cnt);
        exp_t e;
        for (int ch = 0; ch < 16; ch++) e.data[16*ch +: 16] = adc_word(f, ch);
        e.cnt = 16'(cnt);
        e.off = off;
        sb.push_back(e);
    endtask

    int   cv_n, cv_first, cv_last, cs_first, cs_last;
    int   rise_n, rise_bad, busy_n, dv_n, ov_n;
    logic snap_cs, snap_sclk, snap_busy;
    logic [255:0] snap_data;
    logic [15:0]  snap_cnt;

    // Observe instance A for ncyc cycles after trigger cycle t0; optionally
    // drop ENABLE at en_off and pulse reset at rst_off.
    task automatic run_window(input int t0, input int ncyc, input int en_off, input int rst_off);
        int   off;
        logic psclk;
        exp_t e;
        cv_n = 0; cv_first = -1; cv_last = -1; cs_first = -1; cs_last = -1;
        rise_n = 0; rise_bad = 0; busy_n = 0; dv_n = 0; ov_n = 0;
        psclk = SCLK;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            off = cyc - t0;
            if (CONVST === 1'b1) begin
                cv_n++;
                if (cv_first < 0) cv_first = off;
                cv_last = off;
            end
            if (CS_n === 1'b0) begin
                if (cs_first < 0) cs_first = off;
                cs_last = off;
            end
            if (SCLK === 1'b1 && psclk === 1'b0) begin
                if (rise_n < 16 && off != 5 + L_CC + L_CD + 2 * L_CD * rise_n) rise_bad++;
                rise_n++;
            end
            psclk = SCLK;
            if (BUSY === 1'b1) busy_n++;
            if (OVERRUN === 1'b1) ov_n++;
            if (DATA_VALID === 1'b1) begin
                dv_n++;
                if (sb.size() == 0) begin
                    chk("dv_unexpected_off", off, -1);
                end else begin
                    e = sb.pop_front();
                    chk("dv_offset", off, e.off);
                    chk("dv_data", DATA_OUT, e.data);
                    chk("dv_sample_cnt", SAMPLE_CNT, e.cnt);
                    last_exp = e.data;
                end
            end
            if (off == rst_off + 1) begin
                snap_cs = CS_n; snap_sclk = SCLK; snap_busy = BUSY;
                snap_data = DATA_OUT; snap_cnt = SAMPLE_CNT;
            end
            if (off == en_off) ENABLE = 1'b0;
            if (off == rst_off) RESET_n = 1'b0;
            if (off == rst_off + 1) RESET_n = 1'b1;
        end
    endtask

    initial begin
        int t0, off, cvr, ovb_n, ovb_first, ovb_last, dvb;
        logic [255:0] expb;

        // ---- 1: reset with ENABLE high ----
        RESET_n = 1'b0; ENABLE = 1'b1;
        RESET_n_b = 1'b0; ENABLE_b = 1'b1; SDO_b = 16'h00FF;
        cvr = 0;
        repeat (3) begin
            @(negedge clk);
            if (CONVST === 1'b1 || CONVST_b === 1'b1) cvr++;
        end
        chk("rst_convst_seen", cvr, 0);
        chk("rst_cs_n", CS_n, 1'b1);
        chk("rst_sclk", SCLK, 1'b0);
        chk("rst_data_out", DATA_OUT, '0);
        chk("rst_valid", DATA_VALID, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_overrun", OVERRUN, 1'b0);
        chk("rst_sample_cnt", SAMPLE_CNT, 16'd0);
        chk("rst_b_cs_n", CS_n_b, 1'b1);
        chk("rst_b_busy", BUSY_b, 1'b0);
        RESET_n = 1'b1; ENABLE = 1'b0;
        RESET_n_b = 1'b1; ENABLE_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_convst", CONVST, 1'b0);

        // ---- 2: single frame ----
        push_frame(0, 170, 1);
        ENABLE = 1'b1; t0 = cyc;
        run_window(t0, 180, 1, -10);
        chk("t2_convst_n", cv_n, 4);
        chk("t2_convst_first", cv_first, 1);
        chk("t2_convst_last", cv_last, 4);
        chk("t2_cs_first", cs_first, 105);
        chk("t2_cs_last", cs_last, 168);
        chk("t2_sclk_rises", rise_n, 16);
        chk("t2_sclk_rise_misplaced", rise_bad, 0);
        chk("t2_busy_cycles", busy_n, 169);
        chk("t2_dv_n", dv_n, 1);
        chk("t2_overrun_n", ov_n, 0);
        chk("t2_ch0", DATA_OUT[15:0], 16'hA500);
        chk("t2_ch15", DATA_OUT[255:240], 16'hA50F);
        chk("t2_sb_left", sb.size(), 0);

        // ---- 3: periodic, period 400 ----
        for (int k = 0; k < 4; k++) push_frame(1 + k, 170 + 400 * k, 2 + k);
        ENABLE = 1'b1; t0 = cyc;
        run_window(t0, 1400, 1300, -10);
        chk("t3_dv_n", dv_n, 4);
        chk("t3_convst_n", cv_n, 16);
        chk("t3_overrun_n", ov_n, 0);
        chk("t3_sb_left", sb.size(), 0);

        // ---- 4: overrun on instance B, period 100 ----
        for (int ch = 0; ch < 16; ch++) expb[16*ch +: 16] = {16{SDO_b[ch]}};
        ovb_n = 0; ovb_first = -1; ovb_last = -1; dvb = 0;
        ENABLE_b = 1'b1; t0 = cyc;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            off = cyc - t0;
            if (OVERRUN_b === 1'b1) begin
                ovb_n++;
                if (ovb_first < 0) ovb_first = off;
                ovb_last = off;
            end
            if (DATA_VALID_b === 1'b1) begin
                dvb++;
                chk("t4_dv_offset", off, 170 + 200 * (dvb - 1));
                chk("t4_dv_data", DATA_OUT_b, expb);
            end
            if (off == 450) ENABLE_b = 1'b0;
        end
        chk("t4_overrun_n", ovb_n, 2);
        chk("t4_overrun_first", ovb_first, 100);
        chk("t4_overrun_last", ovb_last, 300);
        chk("t4_dv_n", dvb, 3);
        chk("t4_sample_cnt", SAMPLE_CNT_b, 16'd3);

        // ---- 5: ENABLE dropped mid-frame ----
        push_frame(5, 170, 6);
        ENABLE = 1'b1; t0 = cyc;
        run_window(t0, 500, 50, -10);
        chk("t5_convst_n", cv_n, 4);
        chk("t5_dv_n", dv_n, 1);
        chk("t5_overrun_n", ov_n, 0);
        chk("t5_data_hold", DATA_OUT, last_exp);
        chk("t5_sb_left", sb.size(), 0);

        // ---- 6: reset during SHIFT ----
        ENABLE = 1'b1; t0 = cyc;
        run_window(t0, 300, 1, 130);
        chk("t6_convst_first", cv_first, 1);
        chk("t6_convst_n", cv_n, 4);
        chk("t6_dv_n", dv_n, 0);
        chk("t6_cs_n_after_rst", snap_cs, 1'b1);
        chk("t6_sclk_after_rst", snap_sclk, 1'b0);
        chk("t6_busy_after_rst", snap_busy, 1'b0);
        chk("t6_data_after_rst", snap_data, '0);
        chk("t6_cnt_after_rst", snap_cnt, 16'd0);
        push_frame(7, 170, 1);
        ENABLE = 1'b1; t0 = cyc;
        run_window(t0, 180, 1, -10);
        chk("t6_restart_dv_n", dv_n, 1);
        chk("t6_sb_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
